bt_slot_sched: RTL and testbench
================================

Name: bt_slot_sched

Overview:
- Master-side TX slot scheduler, driven by the master piconet clock timing (slot pulse plus CLK bit 1).
- Decides at each master RX-slot end who owns the next master TX slot:
  - the periodic reserved SCO link, or
  - one of NREQ ACL requesters, chosen round-robin.
- Limits multi-slot ACL packets so they never overlap a reserved SCO slot.
- Tracks the TX/RX exchange until the next decision point and feeds grants to the packet builder and hop-select logic.

Parameters:
- NREQ, 4, number of ACL requesters (2..8).
- IW, 2, width of grant index = clog2(NREQ).

Ports:
- clk_6M  in  1  6 MHz system clock.
- rstz  in  1  reset.
- tslot_p  in  1  one-cycle master slot-boundary pulse (625 us).
- clk1  in  1  master CLK bit 1; 0 = TX slot, 1 = RX slot.
- sched_en  in  1  scheduler enable.
- abort_p  in  1  one-cycle pulse: abort current exchange.
- acl_req  in  NREQ  per-requester TX request (level).
- acl_slots  in  3*NREQ  requested packet length per requester: 1, 3 or 5.
- rx_busy  in  1  receiver is inside a multi-slot slave packet.
- regi_sco_en  in  1  SCO reservation enable.
- regi_tsco_frm  in  2  SCO period in frames (1..3, i.e. Tsco 2/4/6 slots).
- sco_start_p  in  1  load SCO phase.
- regi_dsco_frm  in  2  SCO offset in frames (< regi_tsco_frm).
- grant  out  NREQ  one-hot ACL grant, held for the exchange.
- grant_sco  out  1  reserved SCO frame granted.
- grant_slots  out  3  granted TX length: 1, 3 or 5.
- tx_start_p  out  1  one-cycle pulse on a decision that grants anyone.
- sched_busy  out  1  exchange in progress.
- sco_miss_p  out  1  reserved frame fell while busy.

Behaviour:
- Decided: reset rstz, asynchronous, active-low; clock clk_6M.
- All outputs reset to 0. The round-robin pointer resets to NREQ-1, so index 0 is favoured first.
- Decision point is dp = tslot_p & clk1. Decision, grant outputs and tx_start_p update on the clk_6M edge where dp is sampled (registered, latency 1).
- SCO phase counter sco_cnt (2 bits):
  - sco_start_p loads regi_dsco_frm.
  - Otherwise, at each dp: if sco_cnt == 0, reload regi_tsco_frm - 1; else decrement.
  - The frame is reserved when regi_sco_en and sco_cnt == 0, evaluated before the update.
  - If sco_start_p and dp coincide, the load wins and the frame is not reserved.
- FSM has three states: IDLE, TX, RX.
- IDLE, at dp with sched_en:
  - Reserved frame: grant_sco = 1, grant_slots = 1, go to TX.
  - Else any acl_req: pick the first requester after the pointer, cyclically; one-hot grant; pointer = winner; go to TX.
  - Else stay in IDLE with no grant.
- ACL length:
  - n = frames until the next reserved frame (sco_cnt after update + 1); with SCO disabled, n is unlimited.
  - grant_slots = min(acl_slots[i], 2n-1), rounded down to 1/3/5.
  - An acl_slots code other than 1/3/5 is treated as 1.
- TX state:
  - Down-counter loaded with grant_slots, decremented on each tslot_p.
  - At 0, go to RX; grants stay held.
- RX state:
  - At dp with rx_busy == 0: drop all grants, then re-arbitrate in the same cycle as IDLE does, so back-to-back exchanges have no gap.
  - At dp with rx_busy == 1: stay in RX.
  - If the frame skipped this way, or any frame decided while not in IDLE, was reserved, pulse sco_miss_p. sco_cnt still advances.
- sched_busy = state != IDLE.
- abort_p or sched_en low: next cycle go to IDLE and clear grants. The pointer and sco_cnt are kept. abort_p coinciding with dp wins, so no grant is issued.
- A requester dropping acl_req mid-exchange does not revoke its grant.

Optional Feature:
- Macro BT_SCHED_POLL_EN adds input regi_tpoll[7:0] and output poll_p.
- A per-requester slot-pair counter is cleared when that requester is granted and incremented at each dp.
- When it reaches regi_tpoll (nonzero), that requester wins the next non-SCO decision regardless of acl_req or the pointer, with grant_slots = 1 and a poll_p pulse.
- Without the macro: pure round-robin, and the ports are absent.

Decomposition:
- Package bt_sched_pkg holds:
  - FSM state enum (IDLE/TX/RX);
  - slot-length constants 1/3/5;
  - the clamp function (length vs frames).
- One sub-module: bt_rr_arbiter, a NREQ-wide rotating-priority one-hot picker with pointer input and index output.

Test Plan:
- SCO off, acl_req=4'b1010, all lengths 1:
  - grants alternate 4'b0010, 4'b1000 on successive dps;
  - tx_start_p once per frame.
- regi_tsco_frm=3, dsco=0, sco_start_p, then constant acl_req[0] with length 5:
  - frame 0 grant_sco;
  - frame 1 ACL capped to 3 (n=2);
  - next reserved frame granted SCO on time, sco_miss_p never set.
- regi_tsco_frm=1 with SCO on: every frame grant_sco, ACL never granted.
- Length 5 granted, then rx_busy held high across one dp:
  - RX state extends one frame;
  - a reserved frame there raises sco_miss_p.
- abort_p in TX state of a 5-slot packet: next cycle grant=0, sched_busy=0; next dp arbitrates from the saved pointer.
- BT_SCHED_POLL_EN, regi_tpoll=4, acl_req[2] always 0: after 4 frames without a grant, requester 2 gets a 1-slot grant and poll_p pulses.

Source files
------------

// File: rtl/bt_sched_pkg.sv
// bt_sched_pkg: shared types, slot-length constants and length clamp for the slot scheduler
package bt_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_TX, S_RX} state_t;
  localparam logic [2:0] LEN1 = 3'd1;
  localparam logic [2:0] LEN3 = 3'd3;
  localparam logic [2:0] LEN5 = 3'd5;
  // Longest legal length that still fits in frm frames (2*frm-1 slots); illegal codes become 1.
  function automatic logic [2:0] clamp_len(input logic [2:0] len, input logic [2:0] frm, input logic lim_en);
    logic [2:0] r, l;
    r = (len == LEN3 || len == LEN5) ? len : LEN1;
    l = !lim_en ? LEN5 : frm <= 3'd1 ? LEN1 : frm == 3'd2 ? LEN3 : LEN5;
    return r < l ? r : l;
  endfunction
endpackage

// File: rtl/bt_rr_arbiter.sv
// bt_rr_arbiter: rotating-priority one-hot picker, first requester after ptr wins
// Ports: req requests; ptr last winner; gnt one-hot grant; idx winner index; vld any request.
module bt_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            vld
);
  // Scan from farthest to nearest so the nearest requester after ptr is written last.
  always_comb begin
    int j;
    idx = '0;
    vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        idx = IW'(j);
        vld = 1'b1;
      end
    end
    gnt = vld ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/bt_slot_sched.sv
// bt_slot_sched: master TX slot scheduler, reserved SCO frames plus round-robin ACL grants
// Ports: clk_6M/rstz clock and async active-low reset; tslot_p/clk1 master slot timing;
//   sched_en/abort_p control; acl_req/acl_slots ACL requests and lengths; rx_busy slave multi-slot RX;
//   regi_sco_en/regi_tsco_frm/regi_dsco_frm/sco_start_p SCO reservation setup;
//   grant/grant_sco/grant_slots/tx_start_p/sched_busy/sco_miss_p scheduler outputs.
// Build option BT_SCHED_POLL_EN: adds regi_tpoll (poll interval in frames) and poll_p.
module bt_slot_sched
  import bt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              tslot_p,
  input  logic              clk1,
  input  logic              sched_en,
  input  logic              abort_p,
  input  logic [NREQ-1:0]   acl_req,
  input  logic [3*NREQ-1:0] acl_slots,
  input  logic              rx_busy,
  input  logic              regi_sco_en,
  input  logic [1:0]        regi_tsco_frm,
  input  logic              sco_start_p,
  input  logic [1:0]        regi_dsco_frm,
`ifdef BT_SCHED_POLL_EN
  input  logic [7:0]        regi_tpoll,
  output logic              poll_p,
`endif
  output logic [NREQ-1:0]   grant,
  output logic              grant_sco,
  output logic [2:0]        grant_slots,
  output logic              tx_start_p,
  output logic              sched_busy,
  output logic              sco_miss_p
);
  state_t state, state_n;
  logic [2:0] cnt, cnt_n, slots_n, n_frm, req_len;
  logic [NREQ-1:0] grant_n, arb_gnt;
  logic [IW-1:0] ptr, ptr_n, arb_idx;
  logic [1:0] sco_cnt, sco_nxt;
  logic arb_vld, sco_n, start_n, miss_n, dp, rsv, decide, stop;
  assign dp = tslot_p & clk1;
  assign stop = abort_p | ~sched_en;
  assign rsv = regi_sco_en & (sco_cnt == 2'd0) & ~sco_start_p;
  assign sco_nxt = sco_start_p ? regi_dsco_frm : ~dp ? sco_cnt :
                   sco_cnt == 2'd0 ? regi_tsco_frm - 2'd1 : sco_cnt - 2'd1;
  // Frames left before the next reserved frame, counting the one being decided.
  assign n_frm = {1'b0, sco_nxt} + 3'd1;
  assign decide = dp & ~stop & (state == S_IDLE | (state == S_RX & ~rx_busy));
  assign sched_busy = state != S_IDLE;
  assign req_len = acl_slots[3*arb_idx +: 3];
  bt_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(acl_req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .vld(arb_vld)
  );
`ifdef BT_SCHED_POLL_EN
  logic [7:0] pcnt [NREQ];
  logic [NREQ-1:0] due, poll_gnt;
  logic poll_n;
  for (genvar i = 0; i < NREQ; i++) begin : g_poll
    assign due[i] = regi_tpoll != 8'd0 && pcnt[i] >= regi_tpoll;
    always_ff @(posedge clk_6M or negedge rstz)
      if (!rstz) pcnt[i] <= '0;
      else if (dp) pcnt[i] <= start_n & grant_n[i] ? 8'd0 : pcnt[i] + {7'd0, pcnt[i] != 8'hff};
  end
  assign poll_gnt = due & (~due + NREQ'(1));
  always_ff @(posedge clk_6M or negedge rstz)
    if (!rstz) poll_p <= 1'b0;
    else poll_p <= poll_n;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    grant_n = grant;
    sco_n = grant_sco;
    slots_n = grant_slots;
    ptr_n = ptr;
    start_n = 1'b0;
    miss_n = dp & rsv & (state == S_TX | (state == S_RX & rx_busy));
`ifdef BT_SCHED_POLL_EN
    poll_n = 1'b0;
`endif
    if (stop | decide) begin
      state_n = S_IDLE;
      cnt_n = '0;
      grant_n = '0;
      sco_n = 1'b0;
      slots_n = '0;
    end
    if (decide) begin
      if (rsv) begin
        sco_n = 1'b1;
        slots_n = LEN1;
      end
`ifdef BT_SCHED_POLL_EN
      else if (|due) begin
        grant_n = poll_gnt;
        slots_n = LEN1;
        poll_n = 1'b1;
      end
`endif
      else if (arb_vld) begin
        grant_n = arb_gnt;
        ptr_n = arb_idx;
        slots_n = clamp_len(req_len, n_frm, regi_sco_en);
      end
      start_n = slots_n != 3'd0;
      state_n = start_n ? S_TX : S_IDLE;
      cnt_n = slots_n;
    end else if (!stop && state == S_TX && tslot_p) begin
      cnt_n = cnt - 3'd1;
      state_n = cnt == 3'd1 ? S_RX : S_TX;
    end
  end
  always_ff @(posedge clk_6M or negedge rstz)
    if (!rstz) begin
      state <= S_IDLE;
      cnt <= '0;
      grant <= '0;
      grant_sco <= 1'b0;
      grant_slots <= '0;
      ptr <= IW'(NREQ - 1);
      sco_cnt <= '0;
      tx_start_p <= 1'b0;
      sco_miss_p <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      grant <= grant_n;
      grant_sco <= sco_n;
      grant_slots <= slots_n;
      ptr <= ptr_n;
      sco_cnt <= sco_nxt;
      tx_start_p <= start_n;
      sco_miss_p <= miss_n;
    end
endmodule

// File: tb/tb_bt_slot_sched.sv
// tb_bt_slot_sched: directed self-checking bench for the master slot scheduler
module tb_bt_slot_sched;
  logic clk_6M = 1'b0, rstz = 1'b0, tslot_p = 1'b0, clk1 = 1'b0, sched_en = 1'b0, abort_p = 1'b0;
  logic rx_busy = 1'b0, regi_sco_en = 1'b0, sco_start_p = 1'b0;
  logic [3:0] acl_req = '0;
  logic [11:0] acl_slots = '0;
  logic [1:0] regi_tsco_frm = 2'd1, regi_dsco_frm = 2'd0;
  logic [3:0] grant;
  logic grant_sco, tx_start_p, sched_busy, sco_miss_p;
  logic [2:0] grant_slots;
`ifdef BT_SCHED_POLL_EN
  logic [7:0] regi_tpoll = 8'd0;
  logic poll_p;
`endif
  int n_chk = 0, n_pass = 0;
  always #5 clk_6M = ~clk_6M;
  bt_slot_sched dut (
    .clk_6M(clk_6M),
    .rstz(rstz),
    .tslot_p(tslot_p),
    .clk1(clk1),
    .sched_en(sched_en),
    .abort_p(abort_p),
    .acl_req(acl_req),
    .acl_slots(acl_slots),
    .rx_busy(rx_busy),
    .regi_sco_en(regi_sco_en),
    .regi_tsco_frm(regi_tsco_frm),
    .sco_start_p(sco_start_p),
    .regi_dsco_frm(regi_dsco_frm),
`ifdef BT_SCHED_POLL_EN
    .regi_tpoll(regi_tpoll),
    .poll_p(poll_p),
`endif
    .grant(grant),
    .grant_sco(grant_sco),
    .grant_slots(grant_slots),
    .tx_start_p(tx_start_p),
    .sched_busy(sched_busy),
    .sco_miss_p(sco_miss_p)
  );
  task automatic tick;
    @(posedge clk_6M);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic chk_dec(input string tag, input logic [3:0] g, input logic s, input logic [2:0] len, input logic st);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_sco"}, 32'(grant_sco), 32'(s));
    chk({tag, "_slots"}, 32'(grant_slots), 32'(len));
    chk({tag, "_start"}, 32'(tx_start_p), 32'(st));
  endtask
  task automatic do_reset;
    tslot_p = 1'b0;
    clk1 = 1'b0;
    abort_p = 1'b0;
    rx_busy = 1'b0;
    sco_start_p = 1'b0;
    regi_sco_en = 1'b0;
    acl_req = '0;
    sched_en = 1'b1;
`ifdef BT_SCHED_POLL_EN
    regi_tpoll = 8'd0;
`endif
    rstz = 1'b0;
    tick;
    tick;
    rstz = 1'b1;
    tick;
  endtask
  task automatic slot(input logic c1);
    tick;
    tick;
    clk1 = c1;
    tslot_p = 1'b1;
    tick;
    tslot_p = 1'b0;
  endtask
  task automatic frame;
    slot(1'b0);
    slot(1'b1);
  endtask
  task automatic pulse_start;
    sco_start_p = 1'b1;
    tick;
    sco_start_p = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    do_reset;
    chk_dec("rst", 4'b0000, 1'b0, 3'd0, 1'b0);
    chk("rst_busy", 32'(sched_busy), 0);
    chk("rst_miss", 32'(sco_miss_p), 0);
    // Round robin, SCO off, 1-slot packets
    acl_req = 4'b1010;
    acl_slots = {4{3'd1}};
    slot(1'b1);
    chk_dec("rr0", 4'b0010, 1'b0, 3'd1, 1'b1);
    chk("rr0_busy", 32'(sched_busy), 1);
    slot(1'b0);
    chk("rr0_tx_start", 32'(tx_start_p), 0);
    chk("rr0_tx_busy", 32'(sched_busy), 1);
    slot(1'b1);
    chk_dec("rr1", 4'b1000, 1'b0, 3'd1, 1'b1);
    frame;
    chk_dec("rr2", 4'b0010, 1'b0, 3'd1, 1'b1);
    // SCO every 3 frames, ACL capped before reserved frame
    do_reset;
    regi_sco_en = 1'b1;
    regi_tsco_frm = 2'd3;
    regi_dsco_frm = 2'd0;
    pulse_start;
    acl_req = 4'b0001;
    acl_slots = {3'd1, 3'd1, 3'd1, 3'd5};
    slot(1'b1);
    chk_dec("sco_f0", 4'b0000, 1'b1, 3'd1, 1'b1);
    frame;
    chk_dec("sco_f1", 4'b0001, 1'b0, 3'd3, 1'b1);
    slot(1'b0);
    slot(1'b1);
    chk("sco_f2_hold", 32'(grant), 32'h1);
    chk("sco_f2_miss", 32'(sco_miss_p), 0);
    chk("sco_f2_start", 32'(tx_start_p), 0);
    frame;
    chk_dec("sco_f3", 4'b0000, 1'b1, 3'd1, 1'b1);
    chk("sco_f3_miss", 32'(sco_miss_p), 0);
    // SCO every frame starves ACL
    do_reset;
    regi_sco_en = 1'b1;
    regi_tsco_frm = 2'd1;
    regi_dsco_frm = 2'd0;
    pulse_start;
    acl_req = 4'b1111;
    slot(1'b1);
    chk_dec("t1_a", 4'b0000, 1'b1, 3'd1, 1'b1);
    frame;
    chk_dec("t1_b", 4'b0000, 1'b1, 3'd1, 1'b1);
    frame;
    chk_dec("t1_c", 4'b0000, 1'b1, 3'd1, 1'b1);
    chk("t1_miss", 32'(sco_miss_p), 0);
    // 5-slot packet, RX extended by rx_busy over a reserved frame
    do_reset;
    regi_tsco_frm = 2'd3;
    regi_dsco_frm = 2'd0;
    acl_req = 4'b0001;
    acl_slots = {3'd1, 3'd1, 3'd1, 3'd5};
    slot(1'b1);
    chk_dec("rx_f0", 4'b0001, 1'b0, 3'd5, 1'b1);
    slot(1'b0);
    slot(1'b1);
    slot(1'b0);
    slot(1'b1);
    regi_sco_en = 1'b1;
    pulse_start;
    slot(1'b0);
    chk("rx_busy_out", 32'(sched_busy), 1);
    rx_busy = 1'b1;
    slot(1'b1);
    chk("rx_miss", 32'(sco_miss_p), 1);
    chk("rx_ext_busy", 32'(sched_busy), 1);
    chk("rx_ext_grant", 32'(grant), 32'h1);
    chk("rx_ext_start", 32'(tx_start_p), 0);
    rx_busy = 1'b0;
    slot(1'b0);
    chk("rx_miss_clr", 32'(sco_miss_p), 0);
    slot(1'b1);
    chk_dec("rx_f4", 4'b0001, 1'b0, 3'd3, 1'b1);
    // Abort mid packet keeps the round-robin pointer
    do_reset;
    acl_req = 4'b1010;
    acl_slots = {4{3'd5}};
    slot(1'b1);
    chk_dec("ab_f0", 4'b0010, 1'b0, 3'd5, 1'b1);
    slot(1'b0);
    abort_p = 1'b1;
    tick;
    abort_p = 1'b0;
    chk("ab_grant", 32'(grant), 0);
    chk("ab_busy", 32'(sched_busy), 0);
    chk("ab_slots", 32'(grant_slots), 0);
    abort_p = 1'b1;
    slot(1'b1);
    abort_p = 1'b0;
    chk("ab_dp_grant", 32'(grant), 0);
    chk("ab_dp_start", 32'(tx_start_p), 0);
    slot(1'b1);
    chk_dec("ab_f1", 4'b1000, 1'b0, 3'd5, 1'b1);
    sched_en = 1'b0;
    tick;
    chk("en_off_busy", 32'(sched_busy), 0);
    chk("en_off_grant", 32'(grant), 0);
`ifdef BT_SCHED_POLL_EN
    do_reset;
    regi_tpoll = 8'd4;
    acl_req = 4'b1011;
    acl_slots = {4{3'd1}};
    slot(1'b1);
    chk_dec("poll_1", 4'b0001, 1'b0, 3'd1, 1'b1);
    frame;
    chk_dec("poll_2", 4'b0010, 1'b0, 3'd1, 1'b1);
    frame;
    chk_dec("poll_3", 4'b1000, 1'b0, 3'd1, 1'b1);
    frame;
    chk_dec("poll_4", 4'b0001, 1'b0, 3'd1, 1'b1);
    chk("poll_4_p", 32'(poll_p), 0);
    frame;
    chk_dec("poll_5", 4'b0100, 1'b0, 3'd1, 1'b1);
    chk("poll_5_p", 32'(poll_p), 1);
    frame;
    chk_dec("poll_6", 4'b0010, 1'b0, 3'd1, 1'b1);
    chk("poll_6_p", 32'(poll_p), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
